// File: rtl/core_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle core sequencer: FSM states, trap causes
// and reset values, also consumed by the core top for its ebreak/difftest exit.
package core_seq_ctrl_pkg;

  localparam int unsigned WAIT_W = 16;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_FWAIT  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_MWAIT  = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    TRAP_NONE      = 3'd0,
    TRAP_EBREAK    = 3'd1,
    TRAP_ILLEGAL   = 3'd2,
    TRAP_FETCH_ERR = 3'd3,
    TRAP_MEM_ERR   = 3'd4,
    TRAP_TIMEOUT   = 3'd5
  } trap_e;

  localparam state_e STATE_RST = ST_FETCH;
  localparam trap_e  TRAP_RST  = TRAP_NONE;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FWAIT) || (s == ST_MWAIT);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_wait_timer.sv
// 16-bit wait counter shared by FWAIT and MWAIT; expired_o flags the last
// permitted wait cycle so the FSM can leave on the following edge.
module core_seq_ctrl_wait_timer
  import core_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed wait cycles, so LAST_CNT marks the TIMEOUT-th one.
  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle control FSM sequencing fetch, decode, execute, data memory access
// and writeback, with trap reporting and cycle/retired-instruction counters.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_resp_valid,
  input  logic             ifu_resp_err,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_break,
  input  logic             dec_illegal,
  input  logic             dec_wb_en,
  output logic             lsu_req_valid,
  output logic             lsu_req_wen,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  input  logic             lsu_resp_err,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             wb_sel_mem,
  output logic             halted,
  output logic [2:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [2:0]       state_dbg
);

  state_e           state_q, state_d;
  trap_e            trap_q, trap_d;
  logic             is_load_q, is_load_d;
  logic             is_store_q, is_store_d;
  logic             wb_en_q, wb_en_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             in_wait;
  logic             wait_expired;

  assign in_wait = is_wait_state(state_q);

  core_seq_ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (!in_wait),
    .en_i      (in_wait),
    .expired_o (wait_expired)
  );

  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    wb_en_d    = wb_en_q;
    retire     = 1'b0;
    case (state_q)
      ST_FETCH: if (ifu_req_ready) state_d = ST_FWAIT;
      ST_FWAIT: begin
        // A response arriving on the timeout cycle still completes the fetch.
        if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            state_d = ST_HALT;
            trap_d  = TRAP_FETCH_ERR;
          end else begin
            state_d = ST_DECODE;
          end
        end else if (wait_expired) begin
          state_d = ST_HALT;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        is_load_d  = dec_is_load;
        is_store_d = dec_is_store;
        wb_en_d    = dec_wb_en;
        if (dec_illegal || (dec_is_load && dec_is_store)) begin
          state_d = ST_HALT;
          trap_d  = TRAP_ILLEGAL;
        end else if (dec_is_break) begin
          state_d = ST_HALT;
          trap_d  = TRAP_EBREAK;
          retire  = 1'b1;
        end else if (dec_is_load || dec_is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM: if (lsu_req_ready) state_d = ST_MWAIT;
      ST_MWAIT: begin
        if (lsu_resp_valid) begin
          if (lsu_resp_err) begin
            state_d = ST_HALT;
            trap_d  = TRAP_MEM_ERR;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired) begin
          state_d = ST_HALT;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    cycle_d   = (state_q != ST_HALT) ? cycle_q + CNT_W'(1) : cycle_q;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= STATE_RST;
      trap_q     <= TRAP_RST;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      wb_en_q    <= 1'b0;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      trap_q     <= trap_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      wb_en_q    <= wb_en_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
    end
  end

  // ir_we alone follows the bus: the word is only guaranteed present while
  // ifu_resp_valid is high, so IR must capture it in that same cycle.
  always_comb begin
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    reg_we        = 1'b0;
    wb_sel_mem    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: ifu_req_valid = 1'b1;
        ST_FWAIT: ir_we = ifu_resp_valid && !ifu_resp_err;
        ST_EXEC: begin
          pc_we  = 1'b1;
          reg_we = wb_en_q;
        end
        ST_MEM: begin
          lsu_req_valid = 1'b1;
          lsu_req_wen   = is_store_q;
        end
        ST_WB: begin
          pc_we      = 1'b1;
          reg_we     = is_load_q;
          wb_sel_mem = is_load_q;
        end
        default: ;
      endcase
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign trap_cause  = trap_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl with TIMEOUT=8; expected values hand-derived.
module tb_core_seq_ctrl;

  logic        clock;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic        dec_is_load, dec_is_store, dec_is_break, dec_illegal, dec_wb_en;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic        ir_we, pc_we, reg_we, wb_sel_mem, halted;
  logic [2:0]  trap_cause, state_dbg;
  logic [31:0] cycle_cnt, instret_cnt;

  int checks = 0;
  int errors = 0;

  core_seq_ctrl #(.CNT_W(32), .TIMEOUT(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_err   (ifu_resp_err),
    .dec_is_load    (dec_is_load),
    .dec_is_store   (dec_is_store),
    .dec_is_break   (dec_is_break),
    .dec_illegal    (dec_illegal),
    .dec_wb_en      (dec_wb_en),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_err   (lsu_resp_err),
    .ir_we          (ir_we),
    .pc_we          (pc_we),
    .reg_we         (reg_we),
    .wb_sel_mem     (wb_sel_mem),
    .halted         (halted),
    .trap_cause     (trap_cause),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt),
    .state_dbg      (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_err = 0;
    dec_is_load = 0; dec_is_store = 0; dec_is_break = 0; dec_illegal = 0; dec_wb_en = 0;
    lsu_req_ready = 0; lsu_resp_valid = 0; lsu_resp_err = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // FETCH -> FWAIT -> DECODE with zero-wait handshakes; returns in DECODE.
  task automatic fetch_ok();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b1;
    tick();
    ifu_resp_valid = 1'b0;
  endtask

  // From DECODE, issue a load/store and return on the first MWAIT cycle.
  task automatic mem_to_mwait(input logic st);
    dec_is_load  = !st;
    dec_is_store = st;
    dec_wb_en    = !st;
    tick();
    dec_is_load = 0; dec_is_store = 0; dec_wb_en = 0;
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_ifu_req_forced", 32'(ifu_req_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_trap", 32'(trap_cause), 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ifu_req", 32'(ifu_req_valid), 1);

    // Zero-wait ALU instruction
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1;
    #1;
    chk("alu_fwait_state", 32'(state_dbg), 1);
    chk("alu_ir_we", 32'(ir_we), 1);
    tick();
    ifu_resp_valid = 1'b0; dec_wb_en = 1'b1;
    #1;
    chk("alu_decode_state", 32'(state_dbg), 2);
    chk("alu_decode_ir_we", 32'(ir_we), 0);
    tick();
    dec_wb_en = 1'b0;
    chk("alu_exec_state", 32'(state_dbg), 3);
    chk("alu_exec_pc_we", 32'(pc_we), 1);
    chk("alu_exec_reg_we", 32'(reg_we), 1);
    chk("alu_exec_wb_sel", 32'(wb_sel_mem), 0);
    tick();
    chk("alu_back_fetch", 32'(state_dbg), 0);
    chk("alu_instret", instret_cnt, 1);
    chk("alu_cycle", cycle_cnt, 4);

    // Load: request stalled 3 cycles, response 2 cycles after accept
    do_reset();
    fetch_ok();
    dec_is_load = 1'b1; dec_wb_en = 1'b1;
    tick();
    dec_is_load = 1'b0; dec_wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lsu_req_ready = (i == 3);
      chk("ld_mem_state", 32'(state_dbg), 4);
      chk("ld_req_valid", 32'(lsu_req_valid), 1);
      chk("ld_req_wen", 32'(lsu_req_wen), 0);
      tick();
    end
    lsu_req_ready = 1'b0;
    chk("ld_mwait_state", 32'(state_dbg), 5);
    chk("ld_mwait_req_low", 32'(lsu_req_valid), 0);
    tick();
    lsu_resp_valid = 1'b1;
    chk("ld_mwait2_state", 32'(state_dbg), 5);
    tick();
    lsu_resp_valid = 1'b0;
    chk("ld_wb_state", 32'(state_dbg), 6);
    chk("ld_wb_reg_we", 32'(reg_we), 1);
    chk("ld_wb_sel_mem", 32'(wb_sel_mem), 1);
    chk("ld_wb_pc_we", 32'(pc_we), 1);
    tick();
    chk("ld_cycle", cycle_cnt, 10);
    chk("ld_instret", instret_cnt, 1);

    // Store followed by ebreak, then frozen HALT
    do_reset();
    fetch_ok();
    dec_is_store = 1'b1;
    tick();
    dec_is_store = 1'b0;
    chk("st_req_wen", 32'(lsu_req_wen), 1);
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0; lsu_resp_valid = 1'b1;
    tick();
    lsu_resp_valid = 1'b0;
    chk("st_wb_state", 32'(state_dbg), 6);
    chk("st_wb_reg_we", 32'(reg_we), 0);
    chk("st_wb_pc_we", 32'(pc_we), 1);
    tick();
    fetch_ok();
    dec_is_break = 1'b1;
    tick();
    dec_is_break = 1'b0;
    chk("brk_halted", 32'(halted), 1);
    chk("brk_trap", 32'(trap_cause), 1);
    chk("brk_instret", instret_cnt, 2);
    chk("brk_cycle", cycle_cnt, 9);
    ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1; lsu_req_ready = 1'b1; lsu_resp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_cycle_frozen", cycle_cnt, 9);
    end
    chk("halt_state", 32'(state_dbg), 7);
    chk("halt_instret_frozen", instret_cnt, 2);
    chk("halt_no_ifu_req", 32'(ifu_req_valid), 0);
    chk("halt_no_ir_we", 32'(ir_we), 0);
    chk("halt_no_pc_we", 32'(pc_we), 0);
    chk("halt_no_lsu_req", 32'(lsu_req_valid), 0);

    // Fetch bus error
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_err = 1'b1;
    #1;
    chk("ferr_no_ir_we", 32'(ir_we), 0);
    tick();
    chk("ferr_state", 32'(state_dbg), 7);
    chk("ferr_trap", 32'(trap_cause), 3);
    ifu_resp_err = 1'b0;
    #1;
    chk("ferr_halt_ir_we", 32'(ir_we), 0);
    // Reset while halted
    reset = 1'b1;
    tick();
    chk("halt_rst_state", 32'(state_dbg), 0);
    chk("halt_rst_halted", 32'(halted), 0);
    chk("halt_rst_trap", 32'(trap_cause), 0);
    reset = 1'b0; ifu_resp_valid = 1'b0;
    #1;
    chk("halt_rst_ifu_req", 32'(ifu_req_valid), 1);

    // Illegal opcode, then load+store with ebreak (illegal wins)
    do_reset();
    fetch_ok();
    dec_illegal = 1'b1;
    tick();
    dec_illegal = 1'b0;
    chk("ill_trap", 32'(trap_cause), 2);
    chk("ill_instret", instret_cnt, 0);
    do_reset();
    fetch_ok();
    dec_is_load = 1'b1; dec_is_store = 1'b1; dec_is_break = 1'b1;
    tick();
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_break = 1'b0;
    chk("ldst_trap", 32'(trap_cause), 2);
    chk("ldst_instret", instret_cnt, 0);

    // MWAIT timeout after 8 cycles with no response
    do_reset();
    fetch_ok();
    mem_to_mwait(1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_mwait_hold", 32'(state_dbg), 5);
    end
    tick();
    chk("to_state", 32'(state_dbg), 7);
    chk("to_trap", 32'(trap_cause), 5);

    // Response on the 8th wait cycle wins over timeout
    do_reset();
    fetch_ok();
    mem_to_mwait(1'b0);
    for (int i = 0; i < 7; i++) tick();
    lsu_resp_valid = 1'b1;
    tick();
    lsu_resp_valid = 1'b0;
    chk("to_resp_wb", 32'(state_dbg), 6);
    chk("to_resp_no_trap", 32'(trap_cause), 0);
    tick();
    chk("to_resp_instret", instret_cnt, 1);

    // Memory bus error
    do_reset();
    fetch_ok();
    mem_to_mwait(1'b1);
    lsu_resp_valid = 1'b1; lsu_resp_err = 1'b1;
    tick();
    lsu_resp_valid = 1'b0; lsu_resp_err = 1'b0;
    chk("merr_trap", 32'(trap_cause), 4);

    // FWAIT timeout
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("fto_hold", 32'(state_dbg), 1);
    tick();
    chk("fto_trap", 32'(trap_cause), 5);

    // Reset mid-MWAIT
    do_reset();
    fetch_ok();
    mem_to_mwait(1'b0);
    tick();
    reset = 1'b1; lsu_resp_valid = 1'b1;
    tick();
    lsu_resp_valid = 1'b0;
    chk("mw_rst_state", 32'(state_dbg), 0);
    chk("mw_rst_cycle", cycle_cnt, 0);
    chk("mw_rst_instret", instret_cnt, 0);
    chk("mw_rst_ifu_forced", 32'(ifu_req_valid), 0);
    reset = 1'b0;
    #1;
    chk("mw_rst_ifu_req", 32'(ifu_req_valid), 1);

    // Strobes forced low while reset is high in EXEC
    do_reset();
    fetch_ok();
    dec_wb_en = 1'b1;
    tick();
    dec_wb_en = 1'b0;
    chk("ex_pc_we", 32'(pc_we), 1);
    reset = 1'b1;
    #1;
    chk("ex_rst_pc_we", 32'(pc_we), 0);
    chk("ex_rst_reg_we", 32'(reg_we), 0);
    tick();
    reset = 1'b0;
    chk("ex_rst_state", 32'(state_dbg), 0);
    chk("ex_rst_instret", instret_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
